sync_fifo: RTL and testbench

- Synchronous single-clock FIFO. It is the responder side of the FIFO interface that the class-based bench drives through FIFO_if.
- Accepts write requests (data_in, wr_en) and read requests (rd_en).
- Returns registered read data, handshake acknowledgements, and status flags (full/empty/almost/overflow/underflow).
- Serves as the design-under-test that the bench's scoreboard and coverage collect against.

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_if.sv | 33 +++
 rtl/sync_fifo.sv | 105 ++++++++++
 tb/tb_sync_fifo.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the synchronous FIFO, so the design and its
// bench agree on default width and depth.
package sync_fifo_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef logic [FIFO_WIDTH_DEF-1:0] fifo_word_t;

  // Depth must be a power of two so the pointers wrap by natural overflow.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// FIFO handshake bundle: the master side issues writes and reads, and the slave
// side (the FIFO) returns data and status.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF
);

  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;

  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty
  );

  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO. Handshake outputs and read data are registered, and the
// level flags are decoded combinationally from the occupancy count.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
)(
  input  logic          clk,
  input  logic          rst_n,
  sync_fifo_if.slave    fifo
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo: FIFO_DEPTH must be a power of two and at least 4");
  end

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     r_wr_ptr;
  logic [ADDR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_count_next;
  logic [FIFO_WIDTH-1:0] r_data_out;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_wr_accept;
  logic w_rd_accept;

  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  // Acceptance is judged on the pre-edge count: an empty FIFO rejects a
  // same-cycle read, and a full one rejects a same-cycle write.
  assign w_wr_accept = fifo.wr_en && !w_full;
  assign w_rd_accept = fifo.rd_en && !w_empty;

  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // a path that skips the assignment infers a latch.
  always_comb begin
    w_count_next = r_count;
    case ({w_wr_accept, w_rd_accept})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // NOTE: storage has no reset, so it maps onto plain RAM; the pointers and
  // count are reset instead, which is what discards the stored data.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= fifo.data_in;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_count <= w_count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out  <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ack    <= w_wr_accept;
      r_overflow  <= fifo.wr_en && w_full;
      r_underflow <= fifo.rd_en && w_empty;
      if (w_rd_accept) r_data_out <= r_mem[r_rd_ptr];
    end
  end

  assign fifo.data_out    = r_data_out;
  assign fifo.wr_ack      = r_wr_ack;
  assign fifo.overflow    = r_overflow;
  assign fifo.underflow   = r_underflow;
  assign fifo.full        = w_full;
  assign fifo.empty       = w_empty;
  assign fifo.almostfull  = (r_count == CNT_W'(FIFO_DEPTH - 1));
  assign fifo.almostempty = (r_count == CNT_W'(1));

`ifdef SIM
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_count <= CNT_W'(FIFO_DEPTH));
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DEPTH = FIFO_DEPTH_DEF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_if #(.FIFO_WIDTH(FIFO_WIDTH_DEF)) u_if ();

  sync_fifo #(
    .FIFO_WIDTH (FIFO_WIDTH_DEF),
    .FIFO_DEPTH (DEPTH)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fifo  (u_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stored words in arrival order plus the registered outputs.
  fifo_word_t q[$];
  fifo_word_t exp_dout;
  logic       exp_ack, exp_ovf, exp_udf;

  // {full, empty, almostfull, almostempty, wr_ack, overflow, underflow}
  function automatic logic [6:0] exp_status();
    int n = q.size();
    return {n == DEPTH, n == 0, n == DEPTH - 1, n == 1, exp_ack, exp_ovf, exp_udf};
  endfunction

  function automatic logic [6:0] dut_status();
    return {u_if.full, u_if.empty, u_if.almostfull, u_if.almostempty,
            u_if.wr_ack, u_if.overflow, u_if.underflow};
  endfunction

  task automatic model_reset();
    q.delete();
    exp_dout = '0;
    exp_ack  = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

  // Drive one request cycle, then advance the model; returns #1 after the edge.
  task automatic cycle(input logic wr, input logic rd, input fifo_word_t din);
    bit was_full  = (q.size() == DEPTH);
    bit was_empty = (q.size() == 0);
    u_if.wr_en   = wr;
    u_if.rd_en   = rd;
    u_if.data_in = din;
    @(posedge clk);
    #1;
    exp_ack = wr && !was_full;
    exp_ovf = wr && was_full;
    exp_udf = rd && was_empty;
    if (rd && !was_empty) exp_dout = q.pop_front();
    if (wr && !was_full)  q.push_back(din);
    u_if.wr_en = 1'b0;
    u_if.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    u_if.wr_en   = 1'b0;
    u_if.rd_en   = 1'b0;
    u_if.data_in = '0;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);
    n_checks++;
    if ({dut_status(), u_if.data_out} !== {7'b0100000, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_state: got status=%b dout=%h expected status=0100000 dout=0000",
               dut_status(), u_if.data_out);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b1, 1'b0, fifo_word_t'(i));
      n_checks++;
      if ({dut_status(), u_if.data_out} !== {exp_status(), exp_dout}) begin
        n_fail++;
        $display("FAIL fill_%0d: got status=%b dout=%h expected status=%b dout=%h",
                 i, dut_status(), u_if.data_out, exp_status(), exp_dout);
      end
      if (i == 1 || i == DEPTH - 1 || i == DEPTH) begin
        n_checks++;
        if ({u_if.wr_ack, u_if.almostempty, u_if.almostfull, u_if.full} !==
            {1'b1, i == 1, i == DEPTH - 1, i == DEPTH}) begin
          n_fail++;
          $display("FAIL fill_flag_%0d: got ack/ae/af/full=%b%b%b%b",
                   i, u_if.wr_ack, u_if.almostempty, u_if.almostfull, u_if.full);
        end
      end
    end
    cycle(1'b1, 1'b0, 16'hDEAD);
    n_checks++;
    if ({u_if.overflow, u_if.wr_ack, u_if.full} !== 3'b101) begin
      n_fail++;
      $display("FAIL overflow_write: got ovf/ack/full=%b%b%b expected 101",
               u_if.overflow, u_if.wr_ack, u_if.full);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      n_checks++;
      if (u_if.data_out !== fifo_word_t'(i) || dut_status() !== exp_status()) begin
        n_fail++;
        $display("FAIL drain_%0d: got dout=%h status=%b expected dout=%h status=%b",
                 i, u_if.data_out, dut_status(), fifo_word_t'(i), exp_status());
      end
    end
    n_checks++;
    if (u_if.empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: got empty=%b expected 1", u_if.empty);
    end
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if ({u_if.underflow, u_if.data_out} !== {1'b1, fifo_word_t'(DEPTH)}) begin
      n_fail++;
      $display("FAIL underflow_read: got udf=%b dout=%h expected udf=1 dout=%h",
               u_if.underflow, u_if.data_out, fifo_word_t'(DEPTH));
    end
  endtask

  task automatic test_simul_empty();
    cycle(1'b1, 1'b1, 16'h00AA);
    n_checks++;
    if ({u_if.underflow, u_if.wr_ack, u_if.almostempty, u_if.empty} !== 4'b1110) begin
      n_fail++;
      $display("FAIL simul_empty: got udf/ack/ae/empty=%b%b%b%b expected 1110",
               u_if.underflow, u_if.wr_ack, u_if.almostempty, u_if.empty);
    end
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if ({u_if.data_out, u_if.empty} !== {16'h00AA, 1'b1}) begin
      n_fail++;
      $display("FAIL simul_empty_read: got dout=%h empty=%b expected dout=00aa empty=1",
               u_if.data_out, u_if.empty);
    end
  endtask

  task automatic test_simul_full();
    fifo_word_t first;
    for (int i = 0; i < DEPTH; i++) begin
      fifo_word_t w = fifo_word_t'($urandom);
      if (w == 16'h0BAD) w = 16'h1BAD;
      if (i == 0) first = w;
      cycle(1'b1, 1'b0, w);
    end
    cycle(1'b1, 1'b1, 16'h0BAD);
    n_checks++;
    if ({u_if.overflow, u_if.almostfull, u_if.data_out} !== {2'b11, first}) begin
      n_fail++;
      $display("FAIL simul_full: got ovf=%b af=%b dout=%h expected ovf=1 af=1 dout=%h",
               u_if.overflow, u_if.almostfull, u_if.data_out, first);
    end
    while (q.size() > 0) begin
      cycle(1'b0, 1'b1, '0);
      n_checks++;
      if (u_if.data_out !== exp_dout || u_if.data_out === 16'h0BAD) begin
        n_fail++;
        $display("FAIL simul_full_drain: got dout=%h expected %h", u_if.data_out, exp_dout);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, fifo_word_t'($urandom));
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({u_if.empty, u_if.full, u_if.wr_ack, u_if.data_out} !== {3'b100, 16'h0000}) begin
      n_fail++;
      $display("FAIL async_reset: got empty=%b full=%b ack=%b dout=%h expected 1 0 0 0000",
               u_if.empty, u_if.full, u_if.wr_ack, u_if.data_out);
    end
    #3;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b0, 1'b1, '0);
    n_checks++;
    if ({u_if.underflow, u_if.empty, u_if.data_out} !== {2'b11, 16'h0000}) begin
      n_fail++;
      $display("FAIL post_reset_read: got udf=%b empty=%b dout=%h expected 1 1 0000",
               u_if.underflow, u_if.empty, u_if.data_out);
    end
  endtask

  task automatic test_wrap();
    int writes = 0;
    while (writes < 12 || q.size() > 0) begin
      logic wr = (writes < 12);
      logic rd = (q.size() >= 3) || (writes >= 12);
      cycle(wr, rd, fifo_word_t'($urandom));
      if (wr) writes++;
      n_checks++;
      if ({dut_status(), u_if.data_out} !== {exp_status(), exp_dout}) begin
        n_fail++;
        $display("FAIL wrap: got status=%b dout=%h expected status=%b dout=%h",
                 dut_status(), u_if.data_out, exp_status(), exp_dout);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic wr = ($urandom_range(0, 99) < 55);
      logic rd = ($urandom_range(0, 99) < 45);
      cycle(wr, rd, fifo_word_t'($urandom));
      n_checks++;
      if ({dut_status(), u_if.data_out} !== {exp_status(), exp_dout}) begin
        n_fail++;
        $display("FAIL random_%0d: got status=%b dout=%h expected status=%b dout=%h",
                 i, dut_status(), u_if.data_out, exp_status(), exp_dout);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simul_empty();
    test_simul_full();
    test_async_reset();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
